// File: rtl/cmd_dispatcher.sv
// Command dispatcher: buffers 64-bit instruction words, decodes the head in order
// and issues single-cycle command pulses to per-core engines, tracking each core's ready.
module cmd_dispatcher #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [63:0]               in_data,
  output logic                      in_ready,
  output logic [NUM_CORES-1:0]      core_cmd_valid,
  output logic [8*NUM_CORES-1:0]    core_cmd_opcode,
  output logic [4*NUM_CORES-1:0]    core_cmd_slot,
  output logic [48*NUM_CORES-1:0]   core_cmd_dma_addr,
  input  logic [NUM_CORES-1:0]      core_ready,
  output logic                      busy,
  output logic                      err_bad_core,
  output logic [31:0]               issued_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [7:0]  OP_NOP  = 8'h00;
  localparam logic [7:0]  OP_SYNC = 8'h01;

  typedef enum logic [1:0] {TRK_FREE, TRK_WAIT_LO, TRK_WAIT_HI} trk_e;

  logic [63:0]                  mem_q [FIFO_DEPTH];
  logic [63:0]                  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         head_vld_q, head_vld_d;
  trk_e                         trk_q [NUM_CORES];
  trk_e                         trk_d [NUM_CORES];
  logic [NUM_CORES-1:0]         vld_q, vld_d;
  logic [NUM_CORES-1:0][7:0]    opc_q, opc_d;
  logic [NUM_CORES-1:0][3:0]    slot_q, slot_d;
  logic [NUM_CORES-1:0][47:0]   addr_q, addr_d;
  logic                         bad_q, bad_d;
  logic [31:0]                  iss_q, iss_d;
  logic                         busy_q, busy_d;

  logic        push, pop, all_idle, any_busy;
  logic [63:0] head_word;
  logic [7:0]  head_op;
  logic [3:0]  head_core, head_slot;
  logic [47:0] head_addr;

  assign in_ready  = !rst && (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign head_word = mem_q[rd_ptr_q];
  assign head_op   = head_word[63:56];
  assign head_core = head_word[55:52];
  assign head_slot = head_word[51:48];
  assign head_addr = head_word[47:0];

  assign core_cmd_valid    = vld_q;
  assign core_cmd_opcode   = opc_q;
  assign core_cmd_slot     = slot_q;
  assign core_cmd_dma_addr = addr_q;
  assign busy              = busy_q;
  assign err_bad_core      = bad_q;
  assign issued_count      = iss_q;

  // Head decode, per-core trackers and FIFO bookkeeping
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trk_d      = trk_q;
    vld_d      = '0;
    opc_d      = opc_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    bad_d      = bad_q;
    iss_d      = iss_q;
    pop        = 1'b0;
    all_idle   = 1'b1;
    any_busy   = 1'b0;

    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (trk_q[c] != TRK_FREE || !core_ready[c]) all_idle = 1'b0;
    end

    if (head_vld_q) begin
      if (head_op == OP_NOP) begin
        pop = 1'b1;
      end else if (head_op == OP_SYNC) begin
        pop = all_idle;
      end else if (32'(head_core) >= NUM_CORES) begin
        pop   = 1'b1;
        bad_d = 1'b1;
      end else begin
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
          if (32'(head_core) == c && trk_q[c] == TRK_FREE && core_ready[c]) begin
            pop       = 1'b1;
            vld_d[c]  = 1'b1;
            opc_d[c]  = head_op;
            slot_d[c] = head_slot;
            addr_d[c] = head_addr;
            iss_d     = iss_q + 32'd1;
          end
        end
      end
    end

    // Ready low is only meaningful once the engine has sampled the pulse
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      case (trk_q[c])
        TRK_FREE:    if (vld_d[c]) trk_d[c] = TRK_WAIT_LO;
        TRK_WAIT_LO: if (!vld_q[c] && !core_ready[c]) trk_d[c] = TRK_WAIT_HI;
        TRK_WAIT_HI: if (core_ready[c]) trk_d[c] = TRK_FREE;
        default:     trk_d[c] = TRK_FREE;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // A freshly written word becomes decodable one cycle after it lands
    head_vld_d = (cnt_q - CNT_W'(pop)) != '0;

    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (trk_d[c] != TRK_FREE) any_busy = 1'b1;
    end
    busy_d = (cnt_d != '0) || any_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CORES; c++) trk_q[c] <= TRK_FREE;
      vld_q      <= '0;
      opc_q      <= '0;
      slot_q     <= '0;
      addr_q     <= '0;
      bad_q      <= 1'b0;
      iss_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      trk_q      <= trk_d;
      vld_q      <= vld_d;
      opc_q      <= opc_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      bad_q      <= bad_d;
      iss_q      <= iss_d;
      busy_q     <= busy_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Command dispatcher sitting directly upstream of the per-core NTT engines. It buffers 64-bit instruction words from the host/sequencer in a FIFO and decodes each into opcode/core/slot/DMA address. Instructions are issued strictly in order as single-cycle command pulses to the addressed core. Each core's `ready` handshake is tracked so that a core never receives a second command before it has finished the first; a SYNC barrier waits until every core is idle.

## Interface
Parameters:
- `NUM_CORES`, 2: number of engines driven (1..16).
- `FIFO_DEPTH`, 8: instruction FIFO entries (power of 2, ≥2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: instruction word valid.
- `in_data` in 64: instruction: [63:56] opcode, [55:52] core id, [51:48] slot, [47:0] DMA byte address.
- `in_ready` out 1: FIFO can accept (= !full, forced 0 while `rst`).
- `core_cmd_valid` out NUM_CORES: one-cycle command pulse per core.
- `core_cmd_opcode` out 8*NUM_CORES: opcode, core i at [8i+7:8i].
- `core_cmd_slot` out 4*NUM_CORES: slot, core i at [4i+3:4i].
- `core_cmd_dma_addr` out 48*NUM_CORES: DMA address, core i at [48i+47:48i].
- `core_ready` in NUM_CORES: engine ready (registered in engine; drops the cycle after it samples a command).
- `busy` out 1: FIFO non-empty or any core tracker not FREE.
- `err_bad_core` out 1: sticky; set when an instruction's core id ≥ NUM_CORES.
- `issued_count` out 32: number of commands issued to cores, wraps at 2^32.

## Operation
- FIFO: push on `in_valid && in_ready`; pop when head is consumed (issue, NOP, SYNC release, or bad-core drop). Push and pop are independent; when full, no push that cycle even if a pop occurs.
- Head decode, one decision per cycle, in order (head-of-line blocking):
  - opcode 0x00 NOP: popped, no issue, no count.
  - opcode 0x01 SYNC: held until all trackers are FREE and all `core_ready`=1, then popped; never forwarded.
  - core id ≥ NUM_CORES: popped, dropped, `err_bad_core` set.
  - otherwise: issued when tracker[core] is FREE and `core_ready[core]`=1; else stalled.
- Issue: registered; `core_cmd_valid[c]` high for exactly one cycle; opcode/slot/addr fields for core c update on issue and hold until that core's next issue. `issued_count` increments.
- Per-core tracker FSM:
  - FREE → WAIT_LO on issue.
  - WAIT_LO → WAIT_HI when `core_ready[c]`=0 (sampled from the cycle after the pulse onward).
  - WAIT_HI → FREE when `core_ready[c]`=1.
- Issues to different cores may be back to back on consecutive cycles; re-issue to the same core requires FREE.
- Opcodes are not validated beyond NOP/SYNC; unknown opcodes are forwarded (the engine completes them in DONE with a 1-cycle `ready` low, which the tracker catches).

## Timing
- Reset values: `core_cmd_valid`=0, all field outputs 0, `busy`=0, `err_bad_core`=0, `issued_count`=0, trackers FREE, FIFO empty, `in_ready`=0 during `rst` and 1 on the first cycle after.
- Reset mid-operation: FIFO flushed, trackers FREE, any pulse in flight is dropped (valid=0 next cycle); no gating on `core_ready`.
- Latency: a word pushed at edge t into an empty FIFO with a FREE core gives `core_cmd_valid`=1 after edge t+2 (head visible at t+1, issue registered at t+2).
- Minimum same-core re-issue spacing: pulse cycle, then ≥1 cycle `ready` low, then the cycle `ready` is observed high. Issue occurs on the edge after FREE.
- SYNC releases on the edge after the all-idle condition is first seen; the next instruction may issue on the following edge.
- Counter wraps 0xFFFFFFFF→0 silently.

## Test plan
- Reset check: assert `rst` 3 cycles with `in_valid`=1 → `in_ready`=0, all outputs 0, nothing enqueued; after release `in_ready`=1, `busy`=0.
- Single LOAD: push {0x02, core 0, slot 3, addr 0x1000}; engine model drops `ready` for 4100 cycles → exactly one pulse, fields 0x02/3/0x1000, `issued_count`=1, `busy` returns 0 after `ready` rises.
- Interleave: push NTT→core0, NTT→core1, MULT→core0 → core0 and core1 pulses on consecutive cycles; second core0 pulse only after core0 `ready` low→high.
- SYNC barrier: push LOAD→core0, LOAD→core1, SYNC, STORE→core1, with core0 busy 50 cycles and core1 busy 10 → STORE issues only after core0 `ready` returns, never earlier.
- Bad core + NOP: with NUM_CORES=2, push {0x05, core 5}, NOP, then {0x06, core 1} → `err_bad_core`=1 sticky, only one pulse (core1, 0x06), `issued_count`=1.
- Backpressure: FIFO_DEPTH=8, core0 held busy, push 10 words to core0 → `in_ready` low after 8 accepted; all 10 issue in order once the core cycles.
